irq_timer: RTL
==============

# irq_timer

Memory-mapped 16-bit down-counting timer with an 8-bit prescaler, one-shot or periodic mode, and a sticky expiry flag. It is an interrupt source feeding one bit of the interrupt controller's `i_src_irq` vector. It presents the same 16-bit MMIO slave bus as the other peripherals. Its `o_irq` output is a level that holds until software clears it, which matches the controller's level-based servicing release.

## Interface
- `RESET_RELOAD`, default 16'hFFFF: reset value of the RELOAD register.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_sel`  in  1  peripheral select.
- `i_we`  in  1  write strobe; qualified by `i_sel`.
- `i_re`  in  1  read strobe; qualified by `i_sel`.
- `i_addr`  in  3  register address.
- `i_wdata`  in  16  write data.
- `o_rdata`  out  16  registered read data.
- `o_rdy`  out  1  equals `i_sel`; there are no wait states.
- `o_irq`  out  1  interrupt level, equal to EXPIRED & IRQ_EN.

## Operation
- Register map:
  - 3'b000 CTRL (R/W): [0] EN, [1] PERIODIC, [2] IRQ_EN, [15:8] PRESC.
  - 3'b010 RELOAD (R/W), 16 bits.
  - 3'b100 COUNT (R/W): a write loads COUNT directly.
  - 3'b110 STATUS: [0] EXPIRED, [1] OVR. Both bits are write-1-to-clear.
  - Other addresses read as 0; writes to them are ignored.
- Prescaler `psc` (8 bits) counts only while EN=1.
  - tick = EN && (psc >= PRESC).
  - On a tick, psc becomes 0; otherwise psc increments.
- On a tick:
  - If COUNT != 0, COUNT decrements by 1.
  - If COUNT == 0, an expire event occurs.
    - PERIODIC=1: COUNT reloads from RELOAD.
    - PERIODIC=0: COUNT stays 0 and EN clears.
- Expire event sets EXPIRED. If EXPIRED was already 1, OVR is also set.
- Expiry period = (RELOAD+1)·(PRESC+1) cycles. RELOAD=0 with PRESC=0 expires every cycle.
- CTRL write behaviour:
  - EN 0→1: COUNT loads RELOAD and psc clears.
  - EN 1→1: only PERIODIC, IRQ_EN and PRESC update; COUNT and psc continue. If the new PRESC is below psc, the `>=` compare causes a tick on the next cycle.
  - EN written 0: COUNT freezes and psc clears.
- RELOAD write affects only the next reload; the running COUNT is untouched.
- Collision priorities:
  - COUNT write in the same cycle as a tick: the write wins, psc clears, and no expire event occurs that cycle.
  - STATUS W1C in the same cycle as an expire event: the set wins. EXPIRED stays 1. OVR is set only if EXPIRED was 1 before the write.
  - CTRL EN 0→1 in the same cycle as a COUNT write: the COUNT write wins.
- `o_irq` is combinational from registered EXPIRED and IRQ_EN.
  - Setting IRQ_EN=1 while EXPIRED=1 asserts `o_irq` immediately after the write.
  - Clearing IRQ_EN masks `o_irq` but keeps EXPIRED.
- Reads have no side effects.

## Timing
- Reset (asynchronous, while `i_rst_n`=0):
  - CTRL=0, RELOAD=`RESET_RELOAD`, COUNT=0, psc=0, STATUS=0.
  - `o_rdata`=0, `o_irq`=0.
  - Deassertion is sampled synchronously. Reset mid-count aborts all activity with no pending event retained.
- Reads: `i_sel && i_re` in cycle N gives `o_rdata` valid in N+1.
  - `o_rdata` is 16'h0000 in any cycle following a non-read.
  - Read data reflects register state before any same-cycle write.
- Writes: `i_sel && i_we` in cycle N; the register holds the new value from N+1.
- Expire event on a tick in cycle N: EXPIRED=1 and `o_irq`=1 (if IRQ_EN) from N+1.
- W1C in cycle N with no collision: `o_irq` drops in N+1.
- `i_re` and `i_we` together: both take effect; the read returns the old value.

## Test plan
- Reset and readback:
  - Assert `i_rst_n`=0 mid-count → all outputs 0 immediately.
  - Read RELOAD → 16'hFFFF.
  - Read CTRL → 0.
- Periodic mode: RELOAD=3, PRESC=1, CTRL=16'h0107.
  - First `o_irq` rises 8 cycles after the enable write takes effect.
  - W1C STATUS each time → `o_irq` pulses every 8 cycles.
- One-shot mode: RELOAD=2, PRESC=0, CTRL=16'h0005.
  - Expiry after 3 ticks.
  - CTRL reads 16'h0004 (EN cleared), COUNT reads 0.
  - `o_irq` stays high until W1C; no further expiry.
- Overrun: RELOAD=0, PRESC=0, periodic, no clear.
  - STATUS reads 16'h0003 after 2 expire events.
  - W1C 16'h0003 → STATUS 0 if issued in a non-expiry cycle.
- Collisions:
  - W1C STATUS coincident with an expire event → EXPIRED stays 1.
  - COUNT write (value 5) coincident with a tick → COUNT reads 5 and no expire event.
- Masking: expire with IRQ_EN=0 → `o_irq`=0 and STATUS=1. Then write IRQ_EN=1 → `o_irq`=1 the next cycle.

Source files
------------

// File: rtl/irq_timer.sv
// irq_timer: 16-bit down-counting MMIO timer with 8-bit prescaler,
// one-shot/periodic modes, sticky EXPIRED/OVR flags and a level interrupt.
module irq_timer #(
  parameter logic [15:0] RESET_RELOAD = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [2:0]  i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_rdy,
  output logic        o_irq
);

  localparam logic [2:0] ADDR_CTRL   = 3'b000;
  localparam logic [2:0] ADDR_RELOAD = 3'b010;
  localparam logic [2:0] ADDR_COUNT  = 3'b100;
  localparam logic [2:0] ADDR_STATUS = 3'b110;

  logic        en;
  logic        periodic;
  logic        irq_en;
  logic [7:0]  presc;
  logic [7:0]  psc;
  logic [15:0] reload;
  logic [15:0] count;
  logic        expired;
  logic        ovr;

  logic        wr_ctrl;
  logic        wr_reload;
  logic        wr_count;
  logic        wr_status;
  logic        rd_en;
  logic        en_rise;
  logic        en_stop;
  logic        tick;
  logic        expire;
  logic [1:0]  status_clr;
  logic [15:0] rd_mux;

  // Bus decode, prescaler tick and expire-event qualification.
  always_comb begin
    wr_ctrl    = i_sel & i_we & (i_addr == ADDR_CTRL);
    wr_reload  = i_sel & i_we & (i_addr == ADDR_RELOAD);
    wr_count   = i_sel & i_we & (i_addr == ADDR_COUNT);
    wr_status  = i_sel & i_we & (i_addr == ADDR_STATUS);
    rd_en      = i_sel & i_re;
    en_rise    = wr_ctrl & ~en & i_wdata[0];
    en_stop    = wr_ctrl & ~i_wdata[0];
    tick       = en & (psc >= presc);
    // A direct COUNT write or a stop request pre-empts the terminal tick.
    expire     = tick & (count == 16'd0) & ~wr_count & ~en_stop;
    status_clr = wr_status ? i_wdata[1:0] : 2'b00;
  end

  // Control register; a one-shot expiry drops EN unless software rewrites CTRL.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      presc    <= 8'd0;
    end else if (wr_ctrl) begin
      en       <= i_wdata[0];
      periodic <= i_wdata[1];
      irq_en   <= i_wdata[2];
      presc    <= i_wdata[15:8];
    end else if (expire && !periodic) begin
      en       <= 1'b0;
    end
  end

  // Reload value only takes effect at the next reload or enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      reload <= RESET_RELOAD;
    end else if (wr_reload) begin
      reload <= i_wdata;
    end
  end

  // Prescaler: restarts on enable/disable and on every tick, runs while enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      psc <= 8'd0;
    end else if (en_rise || en_stop || tick) begin
      psc <= 8'd0;
    end else if (en) begin
      psc <= psc + 8'd1;
    end
  end

  // Main counter: direct write beats enable-load, which beats tick activity.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= 16'd0;
    end else if (wr_count) begin
      count <= i_wdata;
    end else if (en_rise) begin
      count <= reload;
    end else if (en_stop) begin
      count <= count;
    end else if (tick) begin
      if (count != 16'd0) begin
        count <= count - 16'd1;
      end else if (periodic) begin
        count <= reload;
      end else begin
        count <= 16'd0;
      end
    end
  end

  // Sticky flags: a same-cycle expire beats W1C; OVR keys off the pre-write EXPIRED.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      expired <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      expired <= expire | (expired & ~status_clr[0]);
      ovr     <= (ovr & ~status_clr[1]) | (expire & expired);
    end
  end

  // Read multiplexer over current (pre-write) register state.
  always_comb begin
    rd_mux = 16'h0000;
    case (i_addr)
      ADDR_CTRL:   rd_mux = {presc, 5'b00000, irq_en, periodic, en};
      ADDR_RELOAD: rd_mux = reload;
      ADDR_COUNT:  rd_mux = count;
      ADDR_STATUS: rd_mux = {14'd0, ovr, expired};
      default:     rd_mux = 16'h0000;
    endcase
  end

  // Registered read data, zero after any non-read cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rdata <= 16'h0000;
    end else begin
      o_rdata <= rd_en ? rd_mux : 16'h0000;
    end
  end

  assign o_rdy = i_sel;
  assign o_irq = expired & irq_en;

endmodule
